fpga_boot_copier: RTL and testbench

//  Read-side initiator for the FPGA bootrom macro port (CEN/A/Q, 1-cycle read latency).
//  On start, copies len_i words from ROM word address src_base_i to L2 byte address dst_base_i.

---
 rtl/fpga_boot_copier_if.sv | 27 ++
 rtl/fpga_boot_copier.sv | 143 ++++++++++++++
 tb/tb_fpga_boot_copier.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fpga_boot_copier_if.sv
// Bus bundle for the boot copier: bootrom macro port (CEN/A/Q) plus the L2 TCDM-style write port.
// The copier drives it through the master modport; ROM and interconnect sit on the slave side.
interface fpga_boot_copier_if #(
   parameter int ROM_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int DST_ADDR_WIDTH = 32
);
   logic                        CEN;
   logic [ROM_ADDR_WIDTH-1:0]   A;
   logic [DATA_WIDTH-1:0]       Q;
   logic                        req_o;
   logic                        gnt_i;
   logic                        we_o;
   logic [DST_ADDR_WIDTH-1:0]   addr_o;
   logic [DATA_WIDTH-1:0]       wdata_o;
   logic [DATA_WIDTH/8-1:0]     be_o;

   modport master (
      output CEN, A, req_o, we_o, addr_o, wdata_o, be_o,
      input  Q, gnt_i
   );

   modport slave (
      input  CEN, A, req_o, we_o, addr_o, wdata_o, be_o,
      output Q, gnt_i
   );
endinterface

// File: rtl/fpga_boot_copier.sv
// Copies a block of bootrom words into L2 before the core leaves its boot trap.
// Keeps one ROM word prefetched so a granted write can be followed by the next one every cycle.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start_i; captures src/dst/len
// S_FETCH | first ROM read issued
// S_LOAD  | first word latched from Q; second read issued if any remain
// S_WRITE | write request held until granted; next word taken from Q
// S_DONE  | one-cycle completion pulse
module fpga_boot_copier #(
   parameter int ROM_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int DST_ADDR_WIDTH = 32,
   parameter int LEN_WIDTH      = 16
) (
   input  logic                       CLK,
   input  logic                       RSTN,
   input  logic                       start_i,
   input  logic [ROM_ADDR_WIDTH-1:0]  src_base_i,
   input  logic [DST_ADDR_WIDTH-1:0]  dst_base_i,
   input  logic [LEN_WIDTH-1:0]       len_i,
   output logic                       busy_o,
   output logic                       done_o,
   fpga_boot_copier_if.master         bus
);
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_WRITE, S_DONE} state_e;

   localparam logic [DST_ADDR_WIDTH-1:0] STRIDE = DST_ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam logic [LEN_WIDTH-1:0]      ONE    = LEN_WIDTH'(1);

   state_e                      state_q, state_d;
   logic [ROM_ADDR_WIDTH-1:0]   src_q, src_d;
   logic [DST_ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]       wdata_q, wdata_d;
   logic [LEN_WIDTH-1:0]        len_q, len_d;
   logic [LEN_WIDTH-1:0]        rd_idx_q, rd_idx_d;
   logic [LEN_WIDTH-1:0]        wr_cnt_q, wr_cnt_d;
   logic                        pf_valid_q, pf_valid_d;
   logic                        cen;
   logic                        req;
   logic                        rd_more;

   assign rd_more = (rd_idx_q < len_q);

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      len_d      = len_q;
      rd_idx_d   = rd_idx_q;
      wr_cnt_d   = wr_cnt_q;
      pf_valid_d = pf_valid_q;
      cen        = 1'b1;
      req        = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               src_d      = src_base_i;
               addr_d     = dst_base_i;
               len_d      = len_i;
               rd_idx_d   = '0;
               wr_cnt_d   = '0;
               pf_valid_d = 1'b0;
               state_d    = (len_i == '0) ? S_DONE : S_FETCH;
            end
         end
         S_FETCH: begin
            cen      = 1'b0;
            rd_idx_d = rd_idx_q + ONE;
            state_d  = S_LOAD;
         end
         S_LOAD: begin
            wdata_d = bus.Q;
            if (rd_more) begin
               cen        = 1'b0;
               rd_idx_d   = rd_idx_q + ONE;
               pf_valid_d = 1'b1;
            end
            state_d = S_WRITE;
         end
         S_WRITE: begin
            req = 1'b1;
            // CEN stays high while stalled so the prefetched word on Q is not overwritten.
            if (bus.gnt_i) begin
               if (wr_cnt_q + ONE == len_q) begin
                  pf_valid_d = 1'b0;
                  state_d    = S_DONE;
               end else begin
                  wr_cnt_d   = wr_cnt_q + ONE;
                  addr_d     = addr_q + STRIDE;
                  wdata_d    = bus.Q;
                  pf_valid_d = rd_more;
                  if (rd_more) begin
                     cen      = 1'b0;
                     rd_idx_d = rd_idx_q + ONE;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q    <= S_IDLE;
         src_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         len_q      <= '0;
         rd_idx_q   <= '0;
         wr_cnt_q   <= '0;
         pf_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         len_q      <= len_d;
         rd_idx_q   <= rd_idx_d;
         wr_cnt_q   <= wr_cnt_d;
         pf_valid_q <= pf_valid_d;
      end
   end

   // ROM address wraps naturally at ROM_ADDR_WIDTH bits.
   assign bus.A       = src_q + ROM_ADDR_WIDTH'(rd_idx_q);
   assign bus.CEN     = cen;
   assign bus.req_o   = req;
   assign bus.we_o    = req;
   assign bus.addr_o  = addr_q;
   assign bus.wdata_o = wdata_q;
   assign bus.be_o    = '1;
   assign busy_o      = (state_q != S_IDLE);
   assign done_o      = (state_q == S_DONE);
endmodule

// File: tb/tb_fpga_boot_copier.sv
// Scoreboard bench for fpga_boot_copier: stimulus queues expected L2 writes and done cycles,
// a negedge monitor compares them as the DUT presents them. A second 4-bit-address instance covers ROM wrap.
module tb_fpga_boot_copier;
   localparam int RAW = 10;
   localparam int DW  = 32;
   localparam int DAW = 32;
   localparam int LW  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic            start = 1'b0;
   logic [RAW-1:0]  src = '0;
   logic [DAW-1:0]  dst = '0;
   logic [LW-1:0]   len = '0;
   logic            busy, done;
   logic            gnt = 1'b1;

   fpga_boot_copier_if #(.ROM_ADDR_WIDTH(RAW), .DATA_WIDTH(DW), .DST_ADDR_WIDTH(DAW)) bus ();
   fpga_boot_copier #(.ROM_ADDR_WIDTH(RAW), .DATA_WIDTH(DW), .DST_ADDR_WIDTH(DAW), .LEN_WIDTH(LW)) dut (
      .CLK(clk), .RSTN(rst_n), .start_i(start), .src_base_i(src), .dst_base_i(dst),
      .len_i(len), .busy_o(busy), .done_o(done), .bus(bus)
   );

   logic            start_w = 1'b0;
   logic [3:0]      src_w = '0;
   logic [DAW-1:0]  dst_w = '0;
   logic [LW-1:0]   len_w = '0;
   logic            busy_w, done_w;

   fpga_boot_copier_if #(.ROM_ADDR_WIDTH(4), .DATA_WIDTH(DW), .DST_ADDR_WIDTH(DAW)) bus_w ();
   fpga_boot_copier #(.ROM_ADDR_WIDTH(4), .DATA_WIDTH(DW), .DST_ADDR_WIDTH(DAW), .LEN_WIDTH(LW)) dut_w (
      .CLK(clk), .RSTN(rst_n), .start_i(start_w), .src_base_i(src_w), .dst_base_i(dst_w),
      .len_i(len_w), .busy_o(busy_w), .done_o(done_w), .bus(bus_w)
   );

   logic [31:0] rom [0:1023];
   logic [31:0] rom_w [0:15];
   logic [31:0] q_r = '0;
   logic [31:0] q_w = '0;
   always @(posedge clk) if (!bus.CEN) q_r <= rom[bus.A];
   always @(posedge clk) if (!bus_w.CEN) q_w <= rom_w[bus_w.A];
   assign bus.Q     = q_r;
   assign bus.gnt_i = gnt;
   assign bus_w.Q     = q_w;
   assign bus_w.gnt_i = 1'b1;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } wr_t;

   wr_t exp_q[$];
   int  done_q[$];
   int  a_seen[$];
   int  errors = 0;
   int  checks = 0;
   int  cyc = 0;
   int  writes_done = 0;
   int  stall_word = -1;
   int  stall_left = 0;
   int  cen_cnt = 0;
   int  done_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Grant is decided at the negedge, then everything is sampled 1ns later.
   always @(negedge clk) begin
      gnt = !(stall_left > 0 && bus.req_o && writes_done == stall_word);
      if (!gnt) stall_left--;
      #1;
      if (rst_n) begin
         if (!bus.CEN) cen_cnt++;
         if (!bus_w.CEN) a_seen.push_back(int'(bus_w.A));
         if (bus.req_o) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_req", 1, 0);
            end else begin
               chk("wr_addr", bus.addr_o, exp_q[0].addr);
               chk("wr_data", bus.wdata_o, exp_q[0].data);
               chk("wr_we_be", {bus.we_o, bus.be_o}, 5'b11111);
               if (!gnt) begin
                  chk("stall_cen", bus.CEN, 1);
               end else begin
                  if (exp_q[0].cyc >= 0) chk("wr_cycle", cyc, exp_q[0].cyc);
                  void'(exp_q.pop_front());
                  writes_done++;
               end
            end
         end
         if (done) begin
            if (done_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("done_cycle", cyc, done_q.pop_front());
            done_seen++;
         end
      end
   end

   task automatic run_copy(input logic [RAW-1:0] s, input logic [31:0] d, input int n,
                           input int sw, input int sn, input bit inject);
      int sc;
      @(negedge clk); #2;
      writes_done = 0; cen_cnt = 0; done_seen = 0;
      stall_word = sw; stall_left = sn;
      start = 1'b1; src = s; dst = d; len = LW'(n);
      sc = cyc;
      for (int i = 0; i < n; i++)
         exp_q.push_back('{d + 32'(4 * i), rom[(int'(s) + i) % 1024], (sn == 0) ? sc + 3 + i : -1});
      done_q.push_back((n == 0) ? sc + 1 : sc + n + 3 + sn);
      @(negedge clk); #2;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      if (inject) begin
         @(negedge clk); #2;
         start = 1'b1; src = 10'd5; dst = 32'h0000_4000; len = 16'd7;
         @(negedge clk); #2;
         start = 1'b0;
      end
      for (int k = 0; k < 200 && done_seen == 0; k++) begin
         @(negedge clk); #2;
      end
      chk("done_seen", done_seen, 1);
      chk("cen_count", cen_cnt, n);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) rom[i] = 32'hB00F_0000 | i;
      rom[0] = 32'h1C00_8537;
      rom[1] = 32'h0805_0513;
      rom[2] = 32'h0005_0067;
      for (int i = 0; i < 16; i++) rom_w[i] = 32'hC0DE_0000 | i;

      #12;
      chk("rst_outputs", {bus.CEN, bus.req_o, bus.we_o, busy, done}, 5'b10000);
      chk("rst_a_addr", {bus.A, bus.addr_o}, 42'd0);
      chk("rst_wdata", bus.wdata_o, 0);
      @(negedge clk); #2;
      rst_n = 1'b1;

      run_copy(10'd0, 32'h1C00_8080, 3, -1, 0, 1'b0);      // basic copy
      run_copy(10'd0, 32'h1C00_8080, 3, 1, 2, 1'b0);       // grant stall on word 1
      run_copy(10'd5, 32'h0000_0100, 0, -1, 0, 1'b0);      // zero length
      run_copy(10'd20, 32'h0000_2000, 5, -1, 0, 1'b1);     // start while busy ignored
      run_copy(10'd100, 32'hFFFF_FFF8, 4, -1, 0, 1'b0);    // destination wrap
      run_copy(10'd1022, 32'h0000_3000, 3, -1, 0, 1'b0);   // 10-bit source wrap

      // Reset one cycle after the first grant, then a full copy.
      @(negedge clk); #2;
      writes_done = 0; cen_cnt = 0; done_seen = 0; stall_left = 0;
      start = 1'b1; src = 10'd0; dst = 32'h1C00_8080; len = 16'd3;
      for (int i = 0; i < 3; i++) exp_q.push_back('{32'h1C00_8080 + 32'(4 * i), rom[i], -1});
      done_q.push_back(-1);
      @(negedge clk); #2;
      start = 1'b0;
      for (int k = 0; k < 50 && writes_done == 0; k++) begin
         @(negedge clk); #2;
      end
      chk("first_grant_seen", writes_done, 1);
      @(negedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_outputs", {bus.CEN, bus.req_o, bus.we_o, busy, done}, 5'b10000);
      chk("midrst_a_addr", {bus.A, bus.addr_o}, 42'd0);
      chk("midrst_wdata", bus.wdata_o, 0);
      exp_q.delete();
      done_q.delete();
      @(negedge clk); #2;
      rst_n = 1'b1;
      run_copy(10'd0, 32'h1C00_8080, 3, -1, 0, 1'b0);

      // 4-bit ROM address: 14,15,0,1
      a_seen.delete();
      @(negedge clk); #2;
      start_w = 1'b1; src_w = 4'd14; dst_w = 32'h0; len_w = 16'd4;
      @(negedge clk); #2;
      start_w = 1'b0;
      for (int k = 0; k < 50 && !done_w; k++) begin
         @(negedge clk); #2;
      end
      chk("wrap_done", done_w, 1);
      chk("wrap_reads", a_seen.size(), 4);
      if (a_seen.size() == 4) begin
         chk("wrap_a0", a_seen[0], 14);
         chk("wrap_a1", a_seen[1], 15);
         chk("wrap_a2", a_seen[2], 0);
         chk("wrap_a3", a_seen[3], 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
